// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage and its program counter.
// The opcode/operand field positions are shared with the control unit.
package fetch_unit_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 5;
    localparam int OPCODE_MSB  = 7;
    localparam int OPCODE_LSB  = 5;
    localparam int OPERAND_MSB = 4;
    localparam int OPERAND_LSB = 0;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

    // PC increment for one cycle: control's advance plus an accepted fetch can stack to +2.
    function automatic logic [1:0] pc_step(input logic advance, input logic fetched);
        return {1'b0, advance} + {1'b0, fetched};
    endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Program counter: jump load, increment by 0/1/2 with wrap modulo 2^ADDR_W, synchronous reset.
// pc_next exposes the value the PC takes at the coming edge.
module program_counter
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              bReset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic [1:0]        step,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next PC: a jump load overrides any increment in the same cycle.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else begin
            pc_d = pc_q + ADDR_W'(step);
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (bReset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_next = pc_d;
    assign pc      = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: memory request/ack handshake, instruction register, valid/ready
// hand-off to control, with jump redirection flushing any fetch already in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int unsigned PC_RESET = 0
) (
    input  logic              clk,
    input  logic              bReset,
    input  logic              hlt,
    input  logic              advance_pc,
    input  logic              pc_in,
    input  logic [DATA_W-1:0] bus_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_busy
);

    localparam logic [ADDR_W-1:0] PC_RST = PC_RESET[ADDR_W-1:0];

    fetch_state_e      state_d, state_q;
    logic [DATA_W-1:0] ir_d, ir_q;
    logic              flush_d, flush_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic              mem_req_q;
    logic              instr_valid_q;
    logic              fetched_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_s;
    logic              bus_unused_s;

    program_counter #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RST)
    ) u_pc (
        .clk      (clk),
        .bReset   (bReset),
        .load     (pc_in),
        .load_val (bus_in[ADDR_W-1:0]),
        .step     (pc_step(advance_pc, fetched_s)),
        .pc_next  (pc_next_s),
        .pc       (pc_s)
    );

    // FSM next state, IR capture and flush tracking.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        flush_d   = flush_q;
        fetched_s = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (!hlt) begin
                    state_d = FS_FETCH;
                end else begin
                    state_d = FS_IDLE;
                end
            end
            FS_FETCH: begin
                if (mem_ack) begin
                    // A jump landing with the ack discards the data just like a pending flush.
                    if (flush_q || pc_in) begin
                        flush_d = 1'b0;
                        state_d = FS_IDLE;
                    end else begin
                        ir_d      = mem_rdata;
                        fetched_s = 1'b1;
                        state_d   = FS_HOLD;
                    end
                end else if (pc_in) begin
                    flush_d = 1'b1;
                end else begin
                    flush_d = flush_q;
                end
            end
            FS_HOLD: begin
                if (instr_ready || pc_in) begin
                    state_d = FS_IDLE;
                end else begin
                    state_d = FS_HOLD;
                end
            end
            default: begin
                state_d = FS_IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    // Request address is latched on FETCH entry so later PC moves cannot disturb it.
    always_comb begin
        mem_addr_d = mem_addr_q;
        if ((state_d == FS_FETCH) && (state_q != FS_FETCH)) begin
            mem_addr_d = pc_next_s;
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    // State, IR, flush and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (bReset) begin
            state_q       <= FS_IDLE;
            ir_q          <= '0;
            flush_q       <= 1'b0;
            mem_addr_q    <= PC_RST;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            flush_q       <= flush_d;
            mem_addr_q    <= mem_addr_d;
            mem_req_q     <= (state_d == FS_FETCH);
            instr_valid_q <= (state_d == FS_HOLD);
        end
    end

    assign bus_unused_s = &{1'b0, bus_in[DATA_W-1:ADDR_W]};

    assign mem_req     = mem_req_q;
    assign fetch_busy  = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instruction = ir_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       bReset, hlt, advance_pc, pc_in, mem_ack, instr_ready;
    logic [7:0] bus_in, mem_rdata;
    logic       mem_req, instr_valid, fetch_busy;
    logic [4:0] mem_addr, pc_out;
    logic [7:0] instruction;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.DATA_W(8), .ADDR_W(5), .PC_RESET(0)) dut (
        .clk         (clk),
        .bReset      (bReset),
        .hlt         (hlt),
        .advance_pc  (advance_pc),
        .pc_in       (pc_in),
        .bus_in      (bus_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .fetch_busy  (fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst, hl, adv, pci;
        bit [7:0] bus;
        bit       ack;
        bit [7:0] rd;
        bit       rdy;
        bit       e_req;
        bit [4:0] e_addr;
        bit       e_val;
        bit [7:0] e_ins;
        bit [4:0] e_pc;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(bit rst, bit hl, bit adv, bit pci, bit [7:0] bus, bit ack,
                                bit [7:0] rd, bit rdy, bit e_req, bit [4:0] e_addr,
                                bit e_val, bit [7:0] e_ins, bit [4:0] e_pc);
        vec_t v;
        v.rst = rst; v.hl = hl; v.adv = adv; v.pci = pci; v.bus = bus; v.ack = ack;
        v.rd = rd; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
        v.e_ins = e_ins; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit req, input bit [4:0] addr, input bit val,
                            input bit [7:0] ins, input bit [4:0] pc);
        chk({tag, "/mem_req"}, 32'(mem_req), 32'(req));
        chk({tag, "/fetch_busy"}, 32'(fetch_busy), 32'(req));
        if (req) chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, "/instr_valid"}, 32'(instr_valid), 32'(val));
        chk({tag, "/instruction"}, 32'(instruction), 32'(ins));
        chk({tag, "/pc_out"}, 32'(pc_out), 32'(pc));
    endtask

    task automatic drive(input bit rst, input bit hl, input bit adv, input bit pci,
                         input bit [7:0] bus, input bit ack, input bit [7:0] rd, input bit rdy);
        bReset = rst; hlt = hl; advance_pc = adv; pc_in = pci; bus_in = bus;
        mem_ack = ack; mem_rdata = rd; instr_ready = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] mem[32];
    int         m_pc, m_addr, npc;
    bit         m_req, m_valid, m_flush, took;
    logic [7:0] m_ir;
    bit         r_rst, r_hlt, r_adv, r_pci, r_ack, r_rdy;
    bit [7:0]   r_bus, r_rd;

    initial begin
        //             rst hl adv pci bus    ack rd     rdy  req addr   val ins    pc
        vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 5'h00, 0, 8'h00, 5'h00);
        vecs[1]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0,  1, 5'h00, 0, 8'h00, 5'h00);
        vecs[2]  = mk(0, 0, 0, 0, 8'h00, 1, 8'hA3, 1,  0, 5'h00, 1, 8'hA3, 5'h01);
        vecs[3]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 5'h00, 0, 8'hA3, 5'h01);
        vecs[4]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0,  1, 5'h01, 0, 8'hA3, 5'h01);
        vecs[5]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0,  1, 5'h01, 0, 8'hA3, 5'h01);
        vecs[6]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0,  1, 5'h01, 0, 8'hA3, 5'h01);
        vecs[7]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0,  1, 5'h01, 0, 8'hA3, 5'h01);
        vecs[8]  = mk(0, 0, 0, 0, 8'h00, 1, 8'h5C, 0,  0, 5'h00, 1, 8'h5C, 5'h02);
        vecs[9]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 5'h00, 1, 8'h5C, 5'h02);
        vecs[10] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 5'h00, 0, 8'h5C, 5'h02);
        vecs[11] = mk(0, 0, 0, 1, 8'h04, 0, 8'h00, 0,  1, 5'h04, 0, 8'h5C, 5'h04);
        vecs[12] = mk(0, 0, 0, 1, 8'h12, 0, 8'h00, 0,  1, 5'h04, 0, 8'h5C, 5'h12);
        vecs[13] = mk(0, 0, 0, 0, 8'h00, 1, 8'h77, 1,  0, 5'h00, 0, 8'h5C, 5'h12);
        vecs[14] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0,  1, 5'h12, 0, 8'h5C, 5'h12);
        vecs[15] = mk(0, 0, 0, 0, 8'h00, 1, 8'hE1, 0,  0, 5'h00, 1, 8'hE1, 5'h13);
        vecs[16] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 5'h00, 0, 8'hE1, 5'h13);
        vecs[17] = mk(0, 1, 0, 0, 8'h00, 1, 8'hFF, 0,  0, 5'h00, 0, 8'hE1, 5'h13);
        vecs[18] = mk(0, 0, 0, 1, 8'hFF, 0, 8'h00, 0,  1, 5'h1F, 0, 8'hE1, 5'h1F);
        vecs[19] = mk(0, 0, 0, 0, 8'h00, 1, 8'h3C, 0,  0, 5'h00, 1, 8'h3C, 5'h00);
        vecs[20] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 5'h00, 0, 8'h3C, 5'h00);
        vecs[21] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0,  1, 5'h00, 0, 8'h3C, 5'h00);
        vecs[22] = mk(0, 0, 0, 0, 8'h00, 1, 8'h9A, 0,  0, 5'h00, 1, 8'h9A, 5'h01);
        vecs[23] = mk(0, 0, 0, 1, 8'h04, 0, 8'h00, 0,  0, 5'h00, 0, 8'h9A, 5'h04);
        vecs[24] = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0,  1, 5'h05, 0, 8'h9A, 5'h05);
        vecs[25] = mk(0, 0, 1, 0, 8'h00, 1, 8'h11, 0,  0, 5'h00, 1, 8'h11, 5'h07);
        vecs[26] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 5'h00, 0, 8'h11, 5'h07);

        drive(1, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        @(negedge clk);
        cyc();

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst, vecs[i].hl, vecs[i].adv, vecs[i].pci, vecs[i].bus,
                  vecs[i].ack, vecs[i].rd, vecs[i].rdy);
            cyc();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val,
                     vecs[i].e_ins, vecs[i].e_pc);
        end

        // hlt held through HOLD: instruction stays, no new request until release + ready.
        drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0); cyc();
        chk_outs("hlt_fetch", 1, 5'h07, 0, 8'h11, 5'h07);
        drive(0, 0, 0, 0, 8'h00, 1, 8'h42, 0); cyc();
        chk_outs("hlt_ack", 0, 5'h00, 1, 8'h42, 5'h08);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 8'h00, 0, 8'h00, 0); cyc();
            chk_outs("hlt_hold", 0, 5'h00, 1, 8'h42, 5'h08);
        end
        drive(0, 1, 0, 0, 8'h00, 0, 8'h00, 1); cyc();
        chk_outs("hlt_consume", 0, 5'h00, 0, 8'h42, 5'h08);
        drive(0, 1, 0, 0, 8'h00, 0, 8'h00, 0); cyc();
        chk_outs("hlt_idle", 0, 5'h00, 0, 8'h42, 5'h08);
        drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0); cyc();
        chk_outs("hlt_release", 1, 5'h08, 0, 8'h42, 5'h08);

        // Reset asserted mid-fetch; a late ack afterwards must not be captured.
        drive(1, 0, 0, 0, 8'h00, 0, 8'h00, 0); cyc();
        chk_outs("rst_midfetch", 0, 5'h00, 0, 8'h00, 5'h00);
        drive(0, 0, 0, 0, 8'h00, 1, 8'h55, 0); cyc();
        chk_outs("rst_late_ack", 1, 5'h00, 0, 8'h00, 5'h00);
        drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0); cyc();
        chk_outs("rst_after", 1, 5'h00, 0, 8'h00, 5'h00);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        m_pc = 0; m_addr = 0; m_req = 0; m_valid = 0; m_flush = 0; m_ir = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            r_rst = (c == 0) || ($urandom_range(0, 249) == 0);
            r_hlt = ($urandom_range(0, 4) == 0);
            r_adv = ($urandom_range(0, 7) == 0);
            r_pci = ($urandom_range(0, 9) == 0);
            r_bus = 8'($urandom);
            r_rdy = ($urandom_range(0, 1) == 0);
            r_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            r_rd  = m_req ? mem[m_addr] : 8'($urandom);
            drive(r_rst, r_hlt, r_adv, r_pci, r_bus, r_ack, r_rd, r_rdy);
            @(posedge clk);
            if (r_rst) begin
                m_pc = 0; m_req = 0; m_valid = 0; m_flush = 0; m_ir = 8'h00;
            end else begin
                took = m_req && r_ack && !m_flush && !r_pci;
                npc  = r_pci ? (int'(r_bus) % 32) : (m_pc + int'(r_adv) + int'(took)) % 32;
                if (m_req) begin
                    if (r_ack) begin
                        if (took) begin
                            m_ir    = r_rd;
                            m_valid = 1;
                        end
                        m_req   = 0;
                        m_flush = 0;
                    end else if (r_pci) begin
                        m_flush = 1;
                    end
                end else if (m_valid) begin
                    if (r_rdy || r_pci) m_valid = 0;
                end else if (!r_hlt) begin
                    m_req  = 1;
                    m_addr = npc;
                end
                m_pc = npc;
            end
            @(negedge clk);
            chk_outs($sformatf("rnd%0d", c), m_req, 5'(m_addr), m_valid, m_ir, 5'(m_pc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
